// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
//
// Bundles the two initiator ports (CPU = port 0, DMAC = port 1), the
// single-port SRAM port and the preempt pulse of mem_bus_arbiter.
//
// Handshake: an initiator raises breqN and holds it for as long as it wants
// the bus. The arbiter answers with bgrtN, a registered level. While bgrtN is
// high, addrN/wdataN/wenN are forwarded to the SRAM, and rdataN returns SRAM
// read data in the same cycle. Dropping breqN ends the tenure at the next
// clock edge. bgrt0 and bgrt1 are never high together, and every handover
// passes through at least one cycle with both grants low.
//
// Modports:
//   slave  : the arbiter (drives grants, SRAM address/data/enable, read data)
//   master : the environment (initiators plus SRAM model)
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          breq0;
  logic          bgrt0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          wen0;
  logic [DW-1:0] rdata0;

  logic          breq1;
  logic          bgrt1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          wen1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic [DW-1:0] mem_rdata;

  logic          preempt;

  modport slave (
    input  breq0, addr0, wdata0, wen0,
    input  breq1, addr1, wdata1, wen1,
    input  mem_rdata,
    output bgrt0, rdata0, bgrt1, rdata1,
    output mem_addr, mem_wdata, mem_wen, preempt
  );

  modport master (
    output breq0, addr0, wdata0, wen0,
    output breq1, addr1, wdata1, wen1,
    output mem_rdata,
    input  bgrt0, rdata0, bgrt1, rdata1,
    input  mem_addr, mem_wdata, mem_wen, preempt
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-initiator arbiter in front of a single-port, asynchronous-read SRAM.
// Grants one initiator at a time, alternates on simultaneous requests, and
// forces a handover when a tenure exceeds MAX_HOLD cycles while the other
// port is waiting (MAX_HOLD = 0 disables that).
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   bus        mem_bus_arbiter_if.slave: breq/bgrt/addr/wdata/wen/rdata for
//              ports 0 and 1, SRAM mem_addr/mem_wdata/mem_wen/mem_rdata,
//              and the one-cycle preempt pulse
//   dbg_state  current arbiter state (0 = IDLE, 1 = GNT0, 2 = GNT1)
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_bus_arbiter_if.slave     bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [8:0] HOLD_LIM   = 9'(MAX_HOLD);

  state_e     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       preempt_q, preempt_d;

  // hold_cnt counts completed granted cycles minus one, so the tenure has
  // used up its budget once hold_cnt + 1 reaches MAX_HOLD.
  logic hold_done;
  assign hold_done = ({1'b0, hold_cnt_q} + 9'd1) >= HOLD_LIM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;   // port 0 wins the first tie
      hold_cnt_q   <= 8'd0;
      preempt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      preempt_q    <= preempt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    preempt_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the port that did not own the bus last time goes first.
        if (bus.breq0 && (!bus.breq1 || last_owner_q)) begin
          state_d    = GNT0;
          hold_cnt_d = 8'd0;
        end else if (bus.breq1) begin
          state_d    = GNT1;
          hold_cnt_d = 8'd0;
        end
      end
      GNT0: begin
        if (!bus.breq0) begin
          state_d      = IDLE;
          last_owner_d = 1'b0;
        end else if (PREEMPT_EN && bus.breq1 && hold_done) begin
          state_d      = IDLE;
          last_owner_d = 1'b0;
          preempt_d    = 1'b1;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      GNT1: begin
        if (!bus.breq1) begin
          state_d      = IDLE;
          last_owner_d = 1'b1;
        end else if (PREEMPT_EN && bus.breq0 && hold_done) begin
          state_d      = IDLE;
          last_owner_d = 1'b1;
          preempt_d    = 1'b1;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath steering is decoded from the registered state only, so a port
  // that is not granted can never reach the SRAM write enable.
  always_comb begin
    bus.bgrt0     = (state_q == GNT0);
    bus.bgrt1     = (state_q == GNT1);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wen   = 1'b0;
    bus.rdata0    = '0;
    bus.rdata1    = '0;
    case (state_q)
      GNT0: begin
        bus.mem_addr  = bus.addr0;
        bus.mem_wdata = bus.wdata0;
        bus.mem_wen   = bus.wen0;
        bus.rdata0    = bus.mem_rdata;
      end
      GNT1: begin
        bus.mem_addr  = bus.addr1;
        bus.mem_wdata = bus.wdata1;
        bus.mem_wen   = bus.wen1;
        bus.rdata1    = bus.mem_rdata;
      end
      default: begin
      end
    endcase
  end

  assign bus.preempt = preempt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Three arbiters (MAX_HOLD = 4, 0, 16) share one set of initiator inputs;
// each has its own SRAM. A reference model tracks bus ownership, tenure
// length and SRAM contents per instance and predicts every output each
// cycle. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  localparam int NI = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       breq0, breq1, wen0, wen1;
  logic [7:0] addr0, wdata0, addr1, wdata1;

  logic       o_bgrt0 [NI];
  logic       o_bgrt1 [NI];
  logic       o_wen   [NI];
  logic       o_pre   [NI];
  logic [7:0] o_addr  [NI];
  logic [7:0] o_wdata [NI];
  logic [7:0] o_rd0   [NI];
  logic [7:0] o_rd1   [NI];
  logic [1:0] o_dbg   [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int HOLD = (k == 0) ? 4 : ((k == 1) ? 0 : 16);
    logic [7:0] sram [256] = '{default: 8'h00};

    mem_bus_arbiter_if #(.AW(8), .DW(8)) bus ();

    assign bus.breq0     = breq0;
    assign bus.addr0     = addr0;
    assign bus.wdata0    = wdata0;
    assign bus.wen0      = wen0;
    assign bus.breq1     = breq1;
    assign bus.addr1     = addr1;
    assign bus.wdata1    = wdata1;
    assign bus.wen1      = wen1;
    assign bus.mem_rdata = sram[bus.mem_addr];

    always @(posedge clk) begin
      if (bus.mem_wen) sram[bus.mem_addr] <= bus.mem_wdata;
    end

    mem_bus_arbiter #(.AW(8), .DW(8), .MAX_HOLD(HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (o_dbg[k])
    );

    assign o_bgrt0[k] = bus.bgrt0;
    assign o_bgrt1[k] = bus.bgrt1;
    assign o_wen[k]   = bus.mem_wen;
    assign o_pre[k]   = bus.preempt;
    assign o_addr[k]  = bus.mem_addr;
    assign o_wdata[k] = bus.mem_wdata;
    assign o_rd0[k]   = bus.rdata0;
    assign o_rd1[k]   = bus.rdata1;
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: owner -1 = nobody, 0/1 = port; cyc = granted cycles so far
  int         hold_of [NI] = '{4, 0, 16};
  int         m_owner [NI];
  int         m_last  [NI];
  int         m_cyc   [NI];
  bit         m_pre   [NI];
  logic [7:0] m_mem   [NI][256];

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (m_owner[k] == 0 && wen0) m_mem[k][addr0] = wdata0;
      if (m_owner[k] == 1 && wen1) m_mem[k][addr1] = wdata1;
      if (rst) begin
        m_owner[k] = -1; m_last[k] = 1; m_cyc[k] = 0; m_pre[k] = 1'b0;
      end else if (m_owner[k] < 0) begin
        m_pre[k] = 1'b0;
        m_cyc[k] = 0;
        if (breq0 && breq1) m_owner[k] = 1 - m_last[k];
        else if (breq0)     m_owner[k] = 0;
        else if (breq1)     m_owner[k] = 1;
      end else begin
        bit want, other;
        want  = (m_owner[k] == 0) ? breq0 : breq1;
        other = (m_owner[k] == 0) ? breq1 : breq0;
        m_cyc[k]++;
        m_pre[k] = 1'b0;
        if (!want) begin
          m_last[k] = m_owner[k]; m_owner[k] = -1;
        end else if (hold_of[k] != 0 && other && m_cyc[k] >= hold_of[k]) begin
          m_last[k] = m_owner[k]; m_owner[k] = -1; m_pre[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < NI; k++) begin
      logic [7:0] ea, ed, er0, er1;
      logic       ew;
      ea = 8'h00; ed = 8'h00; ew = 1'b0; er0 = 8'h00; er1 = 8'h00;
      if (m_owner[k] == 0) begin
        ea = addr0; ed = wdata0; ew = wen0; er0 = m_mem[k][addr0];
      end else if (m_owner[k] == 1) begin
        ea = addr1; ed = wdata1; ew = wen1; er1 = m_mem[k][addr1];
      end
      check($sformatf("bgrt0[%0d]", k), 32'(o_bgrt0[k]), 32'(m_owner[k] == 0));
      check($sformatf("bgrt1[%0d]", k), 32'(o_bgrt1[k]), 32'(m_owner[k] == 1));
      check($sformatf("preempt[%0d]", k), 32'(o_pre[k]), 32'(m_pre[k]));
      check($sformatf("mem_addr[%0d]", k), 32'(o_addr[k]), 32'(ea));
      check($sformatf("mem_wdata[%0d]", k), 32'(o_wdata[k]), 32'(ed));
      check($sformatf("mem_wen[%0d]", k), 32'(o_wen[k]), 32'(ew));
      check($sformatf("rdata0[%0d]", k), 32'(o_rd0[k]), 32'(er0));
      check($sformatf("rdata1[%0d]", k), 32'(o_rd1[k]), 32'(er1));
    end
  endtask

  // driver tasks: drive() applies inputs mid-cycle and checks, tick() advances
  task automatic drive(input logic r, input logic b0, input logic b1,
                       input logic e0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic e1, input logic [7:0] a1, input logic [7:0] d1);
    @(negedge clk);
    rst = r; breq0 = b0; breq1 = b1;
    wen0 = e0; addr0 = a0; wdata0 = d0;
    wen1 = e1; addr1 = a1; wdata1 = d1;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic cyc(input logic r, input logic b0, input logic b1);
    drive(r, b0, b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  initial begin
    int nb1, np0, np1, ng0;
    logic rb0, rb1;

    for (int k = 0; k < NI; k++)
      for (int a = 0; a < 256; a++) m_mem[k][a] = 8'h00;

    rst = 1'b1; breq0 = 1'b0; breq1 = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
    addr0 = 8'h00; wdata0 = 8'h00; addr1 = 8'h00; wdata1 = 8'h00;
    repeat (2) @(posedge clk);
    model_step();

    // reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < NI; k++) begin
      check("rst_bgrt0", 32'(o_bgrt0[k]), 32'd0);
      check("rst_bgrt1", 32'(o_bgrt1[k]), 32'd0);
      check("rst_preempt", 32'(o_pre[k]), 32'd0);
    end
    tick();

    // port 0 alone: one-cycle grant latency, write then read back
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    check("sc1_not_yet", 32'(o_bgrt0[0]), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 8'h00);
    check("sc1_grant", 32'(o_bgrt0[0]), 32'd1);
    check("sc1_wen", 32'(o_wen[0]), 32'd1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00);
    check("sc1_rdata0", 32'(o_rd0[0]), 32'hA5);
    check("sc1_rdata1", 32'(o_rd1[0]), 32'h00);
    tick();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);

    // simultaneous requests alternate
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    check("sc2_first_p0", 32'(o_bgrt0[2]), 32'd1);
    tick();
    cyc(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    check("sc2_turnaround", 32'({o_bgrt0[2], o_bgrt1[2]}), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    check("sc2_then_p1", 32'(o_bgrt1[2]), 32'd1);
    tick();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    check("sc2_p0_again", 32'(o_bgrt0[2]), 32'd1);
    tick();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // non-granted write enable is ignored
    cyc(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 8'h11, 1'b0, 8'h00, 8'h00);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00, 1'b1, 8'h20, 8'hFF);
    check("sc5_no_wen", 32'(o_wen[0]), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 8'h20, 8'hFF);
    check("sc5_unchanged", 32'(o_rd0[0]), 32'h11);
    tick();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // preemption with MAX_HOLD = 4 (instance 0)
    cyc(1'b0, 1'b0, 1'b1);
    nb1 = 0; np0 = 0; np1 = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, (i >= 1 && i <= 6), 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
      if (i <= 7 && o_bgrt1[0]) nb1++;
      if (o_pre[0]) np0++;
      if (o_pre[1]) np1++;
      if (i == 4) check("sc3_pre_idle", 32'({o_bgrt0[0], o_bgrt1[0]}), 32'd0);
      if (i == 5) check("sc3_p0_follows", 32'(o_bgrt0[0]), 32'd1);
      if (i == 9) check("sc3_p1_regrant", 32'(o_bgrt1[0]), 32'd1);
      tick();
    end
    check("sc3_tenure", 32'(nb1), 32'd4);
    check("sc3_pulses", 32'(np0), 32'd1);
    check("sc3_nopre_mh0", 32'(np1), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // MAX_HOLD = 0 never preempts (instance 1)
    cyc(1'b0, 1'b1, 1'b0);
    ng0 = 0; np1 = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
      if (o_bgrt0[1]) ng0++;
      if (o_pre[1]) np1++;
      tick();
    end
    check("sc4_held", 32'(ng0), 32'd100);
    check("sc4_no_preempt", 32'(np1), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // reset in the middle of a port 1 write burst
    cyc(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h40, 8'h77);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h41, 8'h78);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h42, 8'h79);
    for (int k = 0; k < NI; k++) begin
      check("sc6_bgrt1", 32'(o_bgrt1[k]), 32'd0);
      check("sc6_wen", 32'(o_wen[k]), 32'd0);
    end
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    check("sc6_tie_p0", 32'(o_bgrt0[0]), 32'd1);
    tick();
    cyc(1'b0, 1'b0, 1'b0);

    // randomized traffic with sticky requests so long tenures occur
    rb0 = 1'b0; rb1 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) rb0 = ~rb0;
      if ($urandom_range(7) == 0) rb1 = ~rb1;
      drive(($urandom_range(299) == 0), rb0, rb1,
            1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom),
            1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
